// File: rtl/seq_cla_adder32_pkg.sv
// Shared definitions for the sequential nibble-CLA adder: state encoding and slice width.
package seq_cla_adder32_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam int         SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_e;

  // idx counter width; a one-slice unit still needs a 1-bit counter
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_cla_adder32_if.sv
// Operand and result handshakes of the sequential adder, bundled as one interface.
interface seq_cla_adder32_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, busy
  );
endinterface

// File: rtl/seq_cla_adder32_nibble_cla.sv
// 4-bit carry-lookahead cell with block propagate/generate for chaining slices.
module nibble_cla (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in,
  output logic [3:0] S,
  output logic       P_prop,
  output logic       G_prop
);
  logic [3:0] p, g, c;

  assign p = A ^ B;
  assign g = A & B;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

  assign S      = p ^ c;
  assign P_prop = &p;
  assign G_prop = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/seq_cla_adder32.sv
// Multi-cycle add/subtract: one nibble CLA cell reused NSLICE times, carry rippled through a register.
module seq_cla_adder32
  import seq_cla_adder32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  seq_cla_adder32_if.slave   io
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_bits(NSLICE);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_r, b_r, sum_r, sum_nx;
  logic               cout_r, ovf_r, zero_r, out_valid_r;
  logic [SLICE_W-1:0] a_nib, b_nib, s_nib;
  logic               p_blk, g_blk, c_nx;

  assign a_nib = a_r[int'(idx)*SLICE_W +: SLICE_W];
  assign b_nib = b_r[int'(idx)*SLICE_W +: SLICE_W];

  nibble_cla u_cla (
    .A      (a_nib),
    .B      (b_nib),
    .c_in   (carry),
    .S      (s_nib),
    .P_prop (p_blk),
    .G_prop (g_blk)
  );

  assign c_nx = g_blk | (p_blk & carry);

  // full sum as it will look after this cycle's nibble lands; zero/ovf are taken from it
  always_comb begin
    sum_nx = sum_r;
    sum_nx[int'(idx)*SLICE_W +: SLICE_W] = s_nib;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          a_r   <= io.a;
          b_r   <= io.b ^ {WIDTH{io.sub}};
          carry <= io.sub;
          idx   <= '0;
          sum_r <= '0;
          state <= RUN;
        end
        RUN: begin
          sum_r <= sum_nx;
          carry <= c_nx;
          if (idx == LAST) begin
            cout_r <= c_nx;
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (sum_nx[WIDTH-1] != a_r[WIDTH-1]);
            zero_r <= (sum_nx == '0);
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // result registers settle on entry; out_valid follows one cycle later
        DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (io.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.busy      = (state != IDLE);
  assign io.out_valid = out_valid_r;
  assign io.sum       = sum_r;
  assign io.cout      = cout_r;
  assign io.ovf       = ovf_r;
  assign io.zero      = zero_r;
endmodule
